hazard_unit_md: RTL and testbench

Hazard and forwarding controller for the 5-stage MIPS pipeline, parametrised in register-address width and extended for the multi-cycle multiply/divide unit (MDU) and JR.
- Produces the E-stage and D-stage forward selects.
- Detects load-use, branch/JR-compare and HI/LO hazards, and drives StallF/StallD/FlushE.
- Tracks MDU occupancy with an internal countdown.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/md_busy_tracker.sv | 36 +++
 rtl/hazard_unit_md.sv | 149 ++++++++++++++
 tb/tb_hazard_unit_md.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
package hazard_pkg;

  // Operand-select encodings shared by the E-stage and D-stage forwarding muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register-file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // result currently in W
  localparam logic [1:0] FWD_MEM = 2'b10;  // result currently in M

  // Stall causes, used to label which term raised a stall.
  typedef enum logic [1:0] {
    STALL_LW = 2'd0,
    STALL_BR = 2'd1,
    STALL_JR = 2'd2,
    STALL_MD = 2'd3
  } stall_cause_e;

  // One bit per stall cause. The top keeps this internally so checkers can see
  // exactly which term fired in a given cycle.
  typedef struct packed {
    logic lw;
    logic br;
    logic jr;
    logic md;
  } stall_vec_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Countdown that tracks whether a multiply/divide result is still pending.
// An op issued in E at cycle t holds md_busy high for cycles t+1 .. t+LAT.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MdStartE,
  input  logic MdIsDivE,
  output logic MdBusy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt;

  // Load the op latency on issue (a reload while busy simply restarts it),
  // otherwise count down to zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (MdStartE) begin
      cnt <= MdIsDivE ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Busy whenever a result is still in flight.
  assign MdBusy = (cnt != '0);

endmodule

// File: rtl/hazard_unit_md.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline with a
// multi-cycle multiply/divide unit and JR/JALR support.
//
// Pipeline control handshake: there is no valid/ready pair here. StallF and
// StallD hold the fetch and decode registers, and FlushE inserts a bubble
// into E. All three are driven from the same stall term in the same cycle,
// so a stalled instruction stays in D while E receives a bubble.
module hazard_unit_md
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              JumpRegD,
  input  logic              MdStartE,
  input  logic              MdIsDivE,
  input  logic              MdReadD,
  input  logic              MdWriteD,
  input  logic              PerfClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [1:0]        ForwardAD,
  output logic [1:0]        ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MdBusy,
  output logic [PERF_W-1:0] StallCycles
);

  // A source register matches a stage only if it is not r0, equals that
  // stage's destination, and that stage actually writes the register file.
  function automatic logic reg_hit(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              wr);
    return wr && (src != '0) && (src == dst);
  endfunction

  // M has priority over W because it holds the younger value.
  function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
    if (m_hit)      return FWD_MEM;
    else if (w_hit) return FWD_WB;
    else            return FWD_RF;
  endfunction

  logic       use_rs;
  logic       use_rt;
  logic       hit_rs_e_m;
  logic       hit_rt_e_m;
  logic       hit_rs_e_w;
  logic       hit_rt_e_w;
  logic       hit_rs_d_m;
  logic       hit_rt_d_m;
  logic       hit_rs_d_w;
  logic       hit_rt_d_w;
  logic       prod_e_rs;
  logic       prod_e_rt;
  logic       load_m_rs;
  logic       load_m_rt;
  logic       stall;
  stall_vec_t stall_vec;

  // MDU occupancy countdown.
  md_busy_tracker #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .MdStartE (MdStartE),
    .MdIsDivE (MdIsDivE),
    .MdBusy   (MdBusy)
  );

  // Per-operand match terms against the M and W stages.
  always_comb begin
    hit_rs_e_m = reg_hit(RsE, WriteRegM, RegWriteM);
    hit_rt_e_m = reg_hit(RtE, WriteRegM, RegWriteM);
    hit_rs_e_w = reg_hit(RsE, WriteRegW, RegWriteW);
    hit_rt_e_w = reg_hit(RtE, WriteRegW, RegWriteW);
    hit_rs_d_m = reg_hit(RsD, WriteRegM, RegWriteM);
    hit_rt_d_m = reg_hit(RtD, WriteRegM, RegWriteM);
    hit_rs_d_w = reg_hit(RsD, WriteRegW, RegWriteW);
    hit_rt_d_w = reg_hit(RtD, WriteRegW, RegWriteW);
  end

  // Forward selects. When M holds a load, a D-side M match is a stall cycle
  // and a W value would be stale relative to the load, so the D selects are
  // restricted to register file or M in that case.
  always_comb begin
    ForwardAE = fwd_sel(hit_rs_e_m, hit_rs_e_w);
    ForwardBE = fwd_sel(hit_rt_e_m, hit_rt_e_w);
    ForwardAD = fwd_sel(hit_rs_d_m, hit_rs_d_w && !MemtoRegM);
    ForwardBD = fwd_sel(hit_rt_d_m, hit_rt_d_w && !MemtoRegM);
  end

  // Stall terms. The D compare needs its operands in D, so an ALU result
  // still in E or a load still in M cannot reach it in time.
  always_comb begin
    use_rs    = (RsD != '0);
    use_rt    = (RtD != '0);
    prod_e_rs = RegWriteE && (WriteRegE != '0) && (WriteRegE == RsD);
    prod_e_rt = RegWriteE && (WriteRegE != '0) && (WriteRegE == RtD);
    load_m_rs = MemtoRegM && (WriteRegM != '0) && (WriteRegM == RsD);
    load_m_rt = MemtoRegM && (WriteRegM != '0) && (WriteRegM == RtD);

    stall_vec    = '0;
    stall_vec.lw = MemtoRegE && (RtE != '0) &&
                   ((use_rs && (RsD == RtE)) || (use_rt && (RtD == RtE)));
    stall_vec.br = BranchD && (prod_e_rs || prod_e_rt || load_m_rs || load_m_rt);
    stall_vec.jr = JumpRegD && (prod_e_rs || load_m_rs);
    stall_vec.md = (MdReadD || MdWriteD) && (MdBusy || MdStartE);

    stall  = stall_vec.lw | stall_vec.br | stall_vec.jr | stall_vec.md;
    StallF = stall;
    StallD = stall;
    FlushE = stall;
  end

  // Stall-cycle counter: clear wins, otherwise count StallD cycles and
  // saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= '0;
    end else if (PerfClr) begin
      StallCycles <= '0;
    end else if (StallD && (StallCycles != '1)) begin
      StallCycles <= StallCycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_md.sv
// Directed bench for hazard_unit_md: forwarding priority, load-use, branch,
// JR, divide/mfhi interlock, asynchronous reset mid-multiply and the stall
// counter including saturation on a narrow instance.
module tb_hazard_unit_md;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] wr_e, wr_m, wr_w;
  logic       rw_e, rw_m, rw_w;
  logic       m2r_e, m2r_m;
  logic       branch_d, jr_d;
  logic       md_start_e, md_is_div_e, md_read_d, md_write_d;
  logic       perf_clr;

  logic [1:0]  fwd_ae, fwd_be, fwd_ad, fwd_bd;
  logic        stall_f, stall_d, flush_e, md_busy;
  logic [31:0] stall_cycles;

  logic [1:0]  s_fwd_ae, s_fwd_be, s_fwd_ad, s_fwd_bd;
  logic        s_stall_f, s_stall_d, s_flush_e, s_md_busy;
  logic [2:0]  s_stall_cycles;

  int checks;
  int errors;
  logic [0:0] exp_q[$];

  hazard_unit_md u_dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(rs_d), .RtD(rt_d), .RsE(rs_e), .RtE(rt_e),
    .WriteRegE(wr_e), .WriteRegM(wr_m), .WriteRegW(wr_w),
    .RegWriteE(rw_e), .RegWriteM(rw_m), .RegWriteW(rw_w),
    .MemtoRegE(m2r_e), .MemtoRegM(m2r_m),
    .BranchD(branch_d), .JumpRegD(jr_d),
    .MdStartE(md_start_e), .MdIsDivE(md_is_div_e),
    .MdReadD(md_read_d), .MdWriteD(md_write_d),
    .PerfClr(perf_clr),
    .ForwardAE(fwd_ae), .ForwardBE(fwd_be), .ForwardAD(fwd_ad), .ForwardBD(fwd_bd),
    .StallF(stall_f), .StallD(stall_d), .FlushE(flush_e),
    .MdBusy(md_busy), .StallCycles(stall_cycles)
  );

  hazard_unit_md #(.PERF_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .RsD(rs_d), .RtD(rt_d), .RsE(rs_e), .RtE(rt_e),
    .WriteRegE(wr_e), .WriteRegM(wr_m), .WriteRegW(wr_w),
    .RegWriteE(rw_e), .RegWriteM(rw_m), .RegWriteW(rw_w),
    .MemtoRegE(m2r_e), .MemtoRegM(m2r_m),
    .BranchD(branch_d), .JumpRegD(jr_d),
    .MdStartE(md_start_e), .MdIsDivE(md_is_div_e),
    .MdReadD(md_read_d), .MdWriteD(md_write_d),
    .PerfClr(perf_clr),
    .ForwardAE(s_fwd_ae), .ForwardBE(s_fwd_be), .ForwardAD(s_fwd_ad), .ForwardBD(s_fwd_bd),
    .StallF(s_stall_f), .StallD(s_stall_d), .FlushE(s_flush_e),
    .MdBusy(s_md_busy), .StallCycles(s_stall_cycles)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    wr_e = '0; wr_m = '0; wr_w = '0;
    rw_e = 0; rw_m = 0; rw_w = 0; m2r_e = 0; m2r_m = 0;
    branch_d = 0; jr_d = 0;
    md_start_e = 0; md_is_div_e = 0; md_read_d = 0; md_write_d = 0;
    perf_clr = 0;
  endtask

  // Advance one clock; inputs change 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] stall3(input logic s);
    return s ? 32'd7 : 32'd0;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_busy",  md_busy, 0);
    chk("rst_perf",  stall_cycles, 0);
    chk("rst_stall", {stall_f, stall_d, flush_e}, 0);
    chk("rst_fwd",   fwd_ae, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Forwarding priority in E, then D-side selects without a load in M.
    rs_e = 3; rt_e = 3; wr_m = 3; wr_w = 3; rw_m = 1; rw_w = 1;
    #1;
    chk("fwd_ae_m", fwd_ae, 2'b10);
    chk("fwd_be_m", fwd_be, 2'b10);
    rw_m = 0; #1;
    chk("fwd_ae_w", fwd_ae, 2'b01);
    chk("fwd_be_w", fwd_be, 2'b01);
    rs_e = 0; #1;
    chk("fwd_ae_r0", fwd_ae, 2'b00);
    chk("fwd_be_w2", fwd_be, 2'b01);
    idle();
    rs_d = 3; rt_d = 4; wr_m = 4; rw_m = 1; wr_w = 3; rw_w = 1;
    #1;
    chk("fwd_ad_w", fwd_ad, 2'b01);
    chk("fwd_bd_m", fwd_bd, 2'b10);
    chk("fwd_nostall", {stall_f, stall_d, flush_e}, 0);
    cyc();

    // Load-use: one stall cycle, then the load has moved to M.
    idle();
    m2r_e = 1; rw_e = 1; rt_e = 8; wr_e = 8; rs_d = 8;
    #1;
    chk("lw_stall", {stall_f, stall_d, flush_e}, 3'b111);
    cyc();
    idle();
    m2r_m = 1; rw_m = 1; wr_m = 8; rs_d = 8;
    #1;
    chk("lw_release", {stall_f, stall_d, flush_e}, 0);
    idle();
    m2r_e = 1; rt_e = 0; rs_d = 0;
    #1;
    chk("lw_r0", {stall_f, stall_d, flush_e}, 0);
    cyc();

    // Branch after an ALU op: one stall, then forward from M.
    idle();
    branch_d = 1; rw_e = 1; wr_e = 5; rt_d = 5; rs_d = 6;
    #1;
    chk("br_alu_s1", {stall_f, stall_d, flush_e}, 3'b111);
    cyc();
    idle();
    branch_d = 1; rw_m = 1; wr_m = 5; rt_d = 5; rs_d = 6;
    #1;
    chk("br_alu_go", {stall_f, stall_d, flush_e}, 0);
    chk("br_fwd_bd", fwd_bd, 2'b10);
    chk("br_fwd_ad", fwd_ad, 2'b00);
    cyc();

    // Branch after a load: two stalls, then forward from W.
    idle();
    branch_d = 1; m2r_e = 1; rw_e = 1; wr_e = 5; rt_e = 5; rt_d = 5; rs_d = 6;
    #1;
    chk("br_lw_s1", {stall_f, stall_d, flush_e}, 3'b111);
    cyc();
    idle();
    branch_d = 1; m2r_m = 1; rw_m = 1; wr_m = 5; rt_d = 5; rs_d = 6;
    #1;
    chk("br_lw_s2", {stall_f, stall_d, flush_e}, 3'b111);
    cyc();
    idle();
    branch_d = 1; rw_w = 1; wr_w = 5; rt_d = 5; rs_d = 6;
    #1;
    chk("br_lw_go", {stall_f, stall_d, flush_e}, 0);
    chk("br_lw_fwd", fwd_bd, 2'b01);
    cyc();

    // JR only looks at Rs.
    idle();
    jr_d = 1; rs_d = 7; rw_e = 1; wr_e = 7;
    #1;
    chk("jr_rs", {stall_f, stall_d, flush_e}, 3'b111);
    rs_d = 2; rt_d = 7;
    #1;
    chk("jr_rt_ignored", {stall_f, stall_d, flush_e}, 0);
    cyc();

    // Divide issued at t with mfhi waiting in D from t: stall t..t+32.
    idle();
    for (int k = 0; k <= 34; k++) exp_q.push_back((k <= 32) ? 1'b1 : 1'b0);
    md_start_e = 1; md_is_div_e = 1; md_read_d = 1;
    for (int k = 0; k <= 34; k++) begin
      logic [0:0] e;
      #1;
      e = exp_q.pop_front();
      chk($sformatf("div_stall_%0d", k), {stall_f, stall_d, flush_e}, stall3(e));
      chk($sformatf("div_busy_%0d", k), md_busy, (k >= 1 && k <= 32) ? 1 : 0);
      cyc();
      md_start_e = 0; md_is_div_e = 0;
    end
    idle();

    // Reset two cycles into a multiply abandons it immediately.
    md_start_e = 1;
    cyc();
    md_start_e = 0;
    #1;
    chk("mul_busy_t1", md_busy, 1);
    cyc();
    #1;
    chk("mul_busy_t2", md_busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mul_rst_busy", md_busy, 0);
    chk("mul_rst_perf", stall_cycles, 0);
    #2;
    rst_n = 1'b1;
    cyc();
    md_read_d = 1;
    #1;
    chk("mul_rst_nostall", {stall_f, stall_d, flush_e}, 0);
    chk("mul_rst_busy2", md_busy, 0);
    idle();

    // Stall counter: 5 stalls, clear coincident with a stall, then saturate.
    perf_clr = 1;
    cyc();
    perf_clr = 0;
    m2r_e = 1; rt_e = 8; rs_d = 8;
    repeat (5) cyc();
    idle();
    #1;
    chk("perf_5", stall_cycles, 5);
    chk("perf_5_w3", s_stall_cycles, 5);
    m2r_e = 1; rt_e = 8; rs_d = 8; perf_clr = 1;
    cyc();
    perf_clr = 0;
    #1;
    chk("perf_clr", stall_cycles, 0);
    chk("perf_clr_w3", s_stall_cycles, 0);
    repeat (10) cyc();
    idle();
    #1;
    chk("perf_10", stall_cycles, 10);
    chk("perf_sat_w3", s_stall_cycles, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
